cpu7_ifu_fcl: RTL and testbench

Fetch control logic for the cpu7 IFU. The block sequences the fetch datapath (`cpu7_ifu_fdp`). It owns the request/cancel handshake with the instruction memory, the selects for the fetch-PC next-value mux, stale-response discarding after redirects, and a one-entry instruction hold buffer used across EXU stalls. It sits between the EXU redirect/stall signals, the instruction memory port and the fdp datapath.

---
 rtl/cpu7_ifu_fcl_if.sv | 50 +++++
 rtl/cpu7_ifu_fcl.sv | 129 ++++++++++++
 tb/tb_cpu7_ifu_fcl.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/cpu7_ifu_fcl_if.sv
// Fetch-control handshake bundle for the cpu7 IFU.
//
// Groups every non-clock/reset signal of cpu7_ifu_fcl:
//   inputs to the FCL : inst_addr_ok, inst_valid_f (instruction memory),
//                       br_taken, exu_ifu_except, exu_ifu_ertn_e,
//                       exu_ifu_stall_req (EXU)
//   outputs of the FCL: inst_req, inst_cancel (instruction memory),
//                       fcl_fdp_npc_sel_l, fcl_fdp_pcf_en, fcl_fdp_ibuf_we,
//                       fcl_fdp_ibuf_sel, fcl_fdp_valid_f (fdp datapath),
//                       kill_f (redirect indication),
//                       fcl_state (debug view of the FCL state register)
//
// Handshake: a fetch request is accepted in a cycle where inst_req=1 and
// inst_addr_ok=1. Each accepted request returns exactly one inst_valid_f
// pulse, at least one cycle later, even when it was cancelled.
//
// Modports: slave = the FCL itself, master = the environment driving it.
interface cpu7_ifu_fcl_if;
  logic       inst_addr_ok;
  logic       inst_valid_f;
  logic       br_taken;
  logic       exu_ifu_except;
  logic       exu_ifu_ertn_e;
  logic       exu_ifu_stall_req;
  logic       inst_req;
  logic       inst_cancel;
  logic [5:0] fcl_fdp_npc_sel_l;
  logic       fcl_fdp_pcf_en;
  logic       fcl_fdp_ibuf_we;
  logic       fcl_fdp_ibuf_sel;
  logic       fcl_fdp_valid_f;
  logic       kill_f;
  logic [2:0] fcl_state;

  modport slave (
    input  inst_addr_ok, inst_valid_f, br_taken, exu_ifu_except,
           exu_ifu_ertn_e, exu_ifu_stall_req,
    output inst_req, inst_cancel, fcl_fdp_npc_sel_l, fcl_fdp_pcf_en,
           fcl_fdp_ibuf_we, fcl_fdp_ibuf_sel, fcl_fdp_valid_f, kill_f,
           fcl_state
  );

  modport master (
    output inst_addr_ok, inst_valid_f, br_taken, exu_ifu_except,
           exu_ifu_ertn_e, exu_ifu_stall_req,
    input  inst_req, inst_cancel, fcl_fdp_npc_sel_l, fcl_fdp_pcf_en,
           fcl_fdp_ibuf_we, fcl_fdp_ibuf_sel, fcl_fdp_valid_f, kill_f,
           fcl_state
  );
endinterface

// File: rtl/cpu7_ifu_fcl.sv
// cpu7_ifu_fcl: fetch control logic for the cpu7 IFU.
//
// Sequences the fetch datapath: issues/cancels instruction-memory requests,
// drives the one-hot-low next-PC select and PC load enable, discards the
// single stale response left behind by a redirect, and steers the one-entry
// hold buffer used while the EXU is stalled.
//
// Ports:
//   clock  - core clock
//   resetn - asynchronous active-low reset (forces IDLE)
//   fcl    - cpu7_ifu_fcl_if.slave, see the interface file for members
//
// All outputs are combinational from the state register and current inputs.
// The state register is the only flop.
module cpu7_ifu_fcl (
  input  logic          clock,
  input  logic          resetn,
  cpu7_ifu_fcl_if.slave fcl
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_HOLD = 3'd3,
    S_DROP = 3'd4
  } state_t;

  // one-hot-low next-PC selects
  localparam logic [5:0] SEL_INIT = 6'b111110;
  localparam logic [5:0] SEL_HOLD = 6'b111101;
  localparam logic [5:0] SEL_PC4  = 6'b111011;
  localparam logic [5:0] SEL_BR   = 6'b110111;
  localparam logic [5:0] SEL_EENT = 6'b101111;
  localparam logic [5:0] SEL_ERA  = 6'b011111;

  state_t     state;
  state_t     state_nxt;
  logic       redirect;
  logic [5:0] redir_sel;
  logic       req_int;

  assign redirect = fcl.exu_ifu_except | fcl.exu_ifu_ertn_e | fcl.br_taken;

  // Priority: except > ertn > br.
  always_comb begin
    if (fcl.exu_ifu_except)      redir_sel = SEL_EENT;
    else if (fcl.exu_ifu_ertn_e) redir_sel = SEL_ERA;
    else                         redir_sel = SEL_BR;
  end

  assign fcl.inst_req  = req_int;
  assign fcl.fcl_state = state;

  always_comb begin
    state_nxt             = state;
    req_int               = 1'b0;
    fcl.inst_cancel       = 1'b0;
    fcl.kill_f            = 1'b0;
    fcl.fcl_fdp_npc_sel_l = SEL_HOLD;
    fcl.fcl_fdp_pcf_en    = 1'b0;
    fcl.fcl_fdp_ibuf_we   = 1'b0;
    fcl.fcl_fdp_ibuf_sel  = 1'b0;
    fcl.fcl_fdp_valid_f   = 1'b0;

    // A redirect outside IDLE always kills, cancels and reloads the PC;
    // the per-state code below only decides the next state.
    if (redirect && state != S_IDLE) begin
      fcl.inst_cancel       = 1'b1;
      fcl.kill_f            = 1'b1;
      fcl.fcl_fdp_pcf_en    = 1'b1;
      fcl.fcl_fdp_npc_sel_l = redir_sel;
    end

    unique case (state)
      S_IDLE: begin
        fcl.fcl_fdp_npc_sel_l = SEL_INIT;
        fcl.fcl_fdp_pcf_en    = 1'b1;
        state_nxt             = S_REQ;
      end
      S_REQ: begin
        req_int = ~fcl.exu_ifu_stall_req;
        // A request accepted in the same cycle as the cancel still
        // returns one response, which DROP has to swallow.
        if (redirect)
          state_nxt = (req_int && fcl.inst_addr_ok) ? S_DROP : S_REQ;
        else if (req_int && fcl.inst_addr_ok)
          state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (redirect) begin
          state_nxt = fcl.inst_valid_f ? S_REQ : S_DROP;
        end else if (fcl.inst_valid_f && !fcl.exu_ifu_stall_req) begin
          fcl.fcl_fdp_valid_f   = 1'b1;
          fcl.fcl_fdp_npc_sel_l = SEL_PC4;
          fcl.fcl_fdp_pcf_en    = 1'b1;
          state_nxt             = S_REQ;
        end else if (fcl.inst_valid_f) begin
          fcl.fcl_fdp_ibuf_we = 1'b1;
          state_nxt           = S_HOLD;
        end
      end
      S_HOLD: begin
        fcl.fcl_fdp_ibuf_sel = 1'b1;
        if (redirect) begin
          state_nxt = S_REQ;
        end else begin
          fcl.fcl_fdp_valid_f = ~fcl.exu_ifu_stall_req;
          if (!fcl.exu_ifu_stall_req) begin
            fcl.fcl_fdp_npc_sel_l = SEL_PC4;
            fcl.fcl_fdp_pcf_en    = 1'b1;
            state_nxt             = S_REQ;
          end
        end
      end
      S_DROP: begin
        // Only the stale response ends DROP; redirects just move the PC.
        if (fcl.inst_valid_f) state_nxt = S_REQ;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nxt;
  end

endmodule

// File: tb/tb_cpu7_ifu_fcl.sv
// Self-checking bench for cpu7_ifu_fcl: directed scenarios followed by a
// randomized run, with a flag-based reference model of the fetch control.
module tb_cpu7_ifu_fcl;

  localparam int W = 13;
  // {inst_req, inst_cancel, npc_sel_l[5:0], pcf_en, ibuf_we, ibuf_sel, valid_f, kill_f}
  localparam logic [W-1:0] RESET_OUTS = {1'b0, 1'b0, 6'b111110, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

  logic clock;
  logic resetn;

  cpu7_ifu_fcl_if fcl_if ();

  cpu7_ifu_fcl dut (
    .clock  (clock),
    .resetn (resetn),
    .fcl    (fcl_if.slave)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d: got %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] dut_outs();
    return {fcl_if.inst_req, fcl_if.inst_cancel, fcl_if.fcl_fdp_npc_sel_l,
            fcl_if.fcl_fdp_pcf_en, fcl_if.fcl_fdp_ibuf_we, fcl_if.fcl_fdp_ibuf_sel,
            fcl_if.fcl_fdp_valid_f, fcl_if.kill_f};
  endfunction

  // ---------------- reference model ----------------
  // Tracked as facts about the fetch pipe rather than named states:
  //   m_started - the PC has been initialised since reset
  //   m_busy    - one accepted request has not yet returned its response
  //   m_stale   - that outstanding response must be thrown away
  //   m_held    - a fetched instruction sits in the hold buffer
  logic m_started, m_busy, m_stale, m_held, m_acc;

  task automatic model_reset();
    m_started = 1'b0;
    m_busy    = 1'b0;
    m_stale   = 1'b0;
    m_held    = 1'b0;
    m_acc     = 1'b0;
  endtask

  function automatic logic [5:0] redir_target(input logic ex, input logic er);
    if (ex) return 6'b101111;
    if (er) return 6'b011111;
    return 6'b110111;
  endfunction

  // Computes the expected outputs for this cycle and advances the model.
  task automatic model_step(input logic ex, er, br, st, ok, v, output logic [W-1:0] exp);
    logic redir, req, cancel, pcf, we, isel, vld;
    logic [5:0] sel;
    redir = ex | er | br;
    req = 0; cancel = 0; pcf = 0; we = 0; isel = 0; vld = 0;
    sel = 6'b111101;
    m_acc = 1'b0;
    if (m_started && redir) begin
      cancel = 1; pcf = 1; sel = redir_target(ex, er);
    end
    if (!m_started) begin
      sel = 6'b111110; pcf = 1;
      m_started = 1'b1;
    end else if (m_held) begin
      isel = 1;
      if (redir) m_held = 1'b0;
      else begin
        vld = ~st;
        if (!st) begin sel = 6'b111011; pcf = 1; m_held = 1'b0; end
      end
    end else if (m_busy && m_stale) begin
      if (v) begin m_busy = 1'b0; m_stale = 1'b0; end
    end else if (m_busy) begin
      if (redir) begin
        if (v) m_busy = 1'b0;
        else   m_stale = 1'b1;
      end else if (v && !st) begin
        vld = 1; sel = 6'b111011; pcf = 1; m_busy = 1'b0;
      end else if (v) begin
        we = 1; m_busy = 1'b0; m_held = 1'b1;
      end
    end else begin
      req = ~st;
      if (req && ok) begin
        m_acc = 1'b1; m_busy = 1'b1; m_stale = redir;
      end
    end
    exp = {req, cancel, sel, pcf, we, isel, vld, cancel};
  endtask

  // ---------------- driver ----------------
  // Entered just after a rising edge: drives inputs, checks at the falling
  // edge, then returns just after the next rising edge.
  task automatic run_cycle(input logic ex, er, br, st, ok, v);
    logic [W-1:0] exp;
    fcl_if.exu_ifu_except    = ex;
    fcl_if.exu_ifu_ertn_e    = er;
    fcl_if.br_taken          = br;
    fcl_if.exu_ifu_stall_req = st;
    fcl_if.inst_addr_ok      = ok;
    fcl_if.inst_valid_f      = v;
    @(negedge clock);
    if (v) check("resp_legal", {31'd0, m_busy}, 32'd1);
    model_step(ex, er, br, st, ok, v, exp);
    exp_q.push_back(exp);
    check("outs", {19'd0, dut_outs()}, {19'd0, exp_q.pop_front()});
    cyc++;
    @(posedge clock);
    #1;
  endtask

  task automatic drive_idle_inputs();
    fcl_if.exu_ifu_except    = 0;
    fcl_if.exu_ifu_ertn_e    = 0;
    fcl_if.br_taken          = 0;
    fcl_if.exu_ifu_stall_req = 0;
    fcl_if.inst_addr_ok      = 0;
    fcl_if.inst_valid_f      = 0;
  endtask

  // ---------------- stimulus ----------------
  logic pend;
  int   pend_cnt;
  logic r_ex, r_er, r_br, r_st, r_ok, r_v;
  int   stall_run;

  initial begin
    drive_idle_inputs();
    model_reset();
    resetn = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("reset_outs", {19'd0, dut_outs()}, {19'd0, RESET_OUTS});
    resetn = 1'b1;

    // Steady fetch: addr_ok=1, data one cycle later.
    //        ex er br st ok v
    run_cycle(0, 0, 0, 0, 1, 0);   // IDLE
    for (int i = 0; i < 3; i++) begin
      run_cycle(0, 0, 0, 0, 1, 0); // REQ accepted
      run_cycle(0, 0, 0, 0, 0, 1); // WAIT data
    end

    // Branch in WAIT with no data, stale data three cycles later.
    run_cycle(0, 0, 0, 0, 1, 0);
    run_cycle(0, 0, 1, 0, 0, 0);
    run_cycle(0, 0, 0, 0, 0, 0);
    run_cycle(0, 0, 0, 0, 0, 0);
    run_cycle(0, 0, 0, 0, 0, 1);

    // Data during a 4-cycle stall, then release.
    run_cycle(0, 0, 0, 0, 1, 0);
    run_cycle(0, 0, 0, 1, 0, 1);
    for (int i = 0; i < 3; i++) run_cycle(0, 0, 0, 1, 0, 0);
    run_cycle(0, 0, 0, 0, 0, 0);

    // All redirects together in REQ with the request accepted.
    run_cycle(1, 1, 1, 0, 1, 0);
    run_cycle(0, 0, 0, 0, 0, 1);

    // ertn+br in REQ without acceptance, then branch in WAIT and a second
    // redirect while DROP waits for its stale response.
    run_cycle(0, 1, 1, 1, 1, 0);
    run_cycle(0, 0, 0, 0, 1, 0);
    run_cycle(0, 0, 1, 0, 0, 0);
    run_cycle(1, 0, 0, 0, 0, 0);
    run_cycle(0, 0, 0, 0, 0, 1);

    // Asynchronous reset while in HOLD, with a redirect on the inputs.
    run_cycle(0, 0, 0, 0, 1, 0);
    run_cycle(0, 0, 0, 1, 0, 1);
    fcl_if.exu_ifu_stall_req = 0;
    fcl_if.br_taken          = 1;
    fcl_if.inst_addr_ok      = 1;
    #2;
    resetn = 1'b0;
    #1;
    check("async_reset_outs", {19'd0, dut_outs()}, {19'd0, RESET_OUTS});
    model_reset();
    @(posedge clock);
    #1;
    check("reset_hold_outs", {19'd0, dut_outs()}, {19'd0, RESET_OUTS});
    resetn = 1'b1;

    // Randomized run with a legal memory model behind the request port.
    pend = 1'b0;
    pend_cnt = 0;
    stall_run = 0;
    for (int i = 0; i < 4000; i++) begin
      r_ex = ($urandom_range(0, 19) == 0);
      r_er = ($urandom_range(0, 19) == 0);
      r_br = ($urandom_range(0, 9) == 0);
      if (stall_run > 0) begin
        r_st = 1'b1;
        stall_run--;
      end else begin
        r_st = 1'b0;
        if ($urandom_range(0, 5) == 0) stall_run = $urandom_range(0, 5);
      end
      r_ok = ($urandom_range(0, 3) != 0);
      r_v  = 1'b0;
      if (pend) begin
        if (pend_cnt == 0) r_v = 1'b1;
        else pend_cnt--;
      end
      run_cycle(r_ex, r_er, r_br, r_st, r_ok, r_v);
      if (r_v) pend = 1'b0;
      if (m_acc) begin
        pend = 1'b1;
        pend_cnt = $urandom_range(0, 2);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
